// File: rtl/fft_addr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_addr_pkg
//  Description : Shared types, default widths and the bit-reversal helper
//                for the FFT address generator and its datapath neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_addr_pkg;

    // Default geometry: 4096-point maximum FFT, 4-bit size exponent.
    localparam int c_def_addr_width = 12;
    localparam int c_def_log_width  = 4;

    // Bit-reversal helper works on a fixed maximum width; callers truncate.
    localparam int c_rev_max_width  = 32;
    localparam int c_rev_idx_w      = $clog2(c_rev_max_width);

    // Address-sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    // Reverse the low n_bits of value; bits at and above n_bits come back 0.
    function automatic logic [c_rev_max_width-1:0] bit_rev_low(
        input logic [c_rev_max_width-1:0] value,
        input int unsigned                n_bits
    );
        logic [c_rev_max_width-1:0] result;
        logic [c_rev_idx_w-1:0]     src_idx;
        result = '0;
        for (int unsigned i = 0; i < c_rev_max_width; i++) begin
            src_idx = c_rev_idx_w'(n_bits - 1 - i);
            if (i < n_bits) begin
                result[i] = value[src_idx];
            end
        end
        return result;
    endfunction

endpackage : fft_addr_pkg
`default_nettype wire

// File: rtl/fft_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : fft_delay_line
//  Description : Enable-gated shift register of DEPTH stages. While en is low
//                every stage holds, so the latency is counted in enabled
//                cycles rather than clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_delay_line #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one position per enabled cycle; reset clears every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (en) begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[DEPTH-1];

endmodule : fft_delay_line
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fft_addr_gen
//  Description : Natural-order / bit-reversed address sweep over a
//                programmable 2^n_log2-point FFT frame, with a delay-matched
//                address copy for RAM read alignment, start/busy/done
//                handshake, stall and continuous frame repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_addr_gen
    import fft_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = c_def_addr_width,
    parameter int LOG_WIDTH  = c_def_log_width,
    parameter int OUT_DELAY  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LOG_WIDTH-1:0]  n_log2,
    input  logic                  bit_rev_en,
    input  logic                  continuous,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] addr_sel,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  done
);

    // Drain counter only needs to reach OUT_DELAY-1.
    localparam int c_drain_w = $clog2(OUT_DELAY + 1);

    fsm_state_t                 r_state;
    fsm_state_t                 w_next_state;

    logic [ADDR_WIDTH-1:0]      r_count;
    logic [LOG_WIDTH-1:0]       r_n_log2;
    logic                       r_bit_rev;
    logic [c_drain_w-1:0]       r_drain_cnt;

    logic                       w_advance;
    logic [LOG_WIDTH-1:0]       w_n_eff;
    logic [ADDR_WIDTH-1:0]      w_last;
    logic                       w_count_at_last;
    logic                       w_drain_last;
    logic [c_rev_max_width-1:0] w_rev;
    logic [ADDR_WIDTH-1:0]      w_sel;
    logic [ADDR_WIDTH:0]        w_pipe_in;
    logic [ADDR_WIDTH:0]        w_pipe_out;

    assign w_advance = !stall;

    // Clamp the requested size exponent into the legal 1..ADDR_WIDTH range.
    always_comb begin
        w_n_eff = n_log2;
        if (n_log2 == '0) begin
            w_n_eff = LOG_WIDTH'(1);
        end else if (n_log2 > LOG_WIDTH'(ADDR_WIDTH)) begin
            w_n_eff = LOG_WIDTH'(ADDR_WIDTH);
        end
    end

    // Terminal count is 2^n - 1; a shift of ADDR_WIDTH yields all ones.
    assign w_last          = ~({ADDR_WIDTH{1'b1}} << r_n_log2);
    assign w_count_at_last = (r_count == w_last);
    assign w_drain_last    = (r_drain_cnt == c_drain_w'(OUT_DELAY - 1));

    // The count never exceeds the terminal value, so reversing only the low
    // n bits leaves the upper address bits at zero.
    assign w_rev = bit_rev_low(c_rev_max_width'(r_count), 32'(r_n_log2));
    assign w_sel = r_bit_rev ? w_rev[ADDR_WIDTH-1:0] : r_count;

    // Valid marks real frame addresses; IDLE and DRAIN push bubbles.
    assign w_pipe_in = {(r_state == ST_RUN), w_sel};

    fft_delay_line #(
        .WIDTH (ADDR_WIDTH + 1),
        .DEPTH (OUT_DELAY)
    ) u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_advance),
        .din   (w_pipe_in),
        .dout  (w_pipe_out)
    );

    assign addr      = r_count;
    assign addr_sel  = w_sel;
    assign addr_out  = w_pipe_out[ADDR_WIDTH-1:0];
    assign valid_out = w_pipe_out[ADDR_WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a start in IDLE is honoured even while stalled.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_advance && w_count_at_last && !continuous) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_advance && w_drain_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs: done marks the cycle the final valid entry is on
    // addr_out, and is withheld while stalled because that entry holds.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN: begin
                busy = 1'b1;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                done = w_advance && w_drain_last;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Frame counter and per-frame configuration capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_n_log2  <= '0;
            r_bit_rev <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_count <= '0;
                    if (start) begin
                        r_n_log2  <= w_n_eff;
                        r_bit_rev <= bit_rev_en;
                    end
                end
                ST_RUN: begin
                    if (w_advance) begin
                        if (w_count_at_last) begin
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    // Counts enabled DRAIN cycles until the last frame entry reaches addr_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state != ST_DRAIN) begin
            r_drain_cnt <= '0;
        end else if (w_advance) begin
            r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
        end
    end

endmodule : fft_addr_gen
`default_nettype wire

// File: tb/tb_fft_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_addr_gen
//  Description : Self-checking bench for fft_addr_gen: vector table, directed
//                multi-cycle sequences and randomized traffic against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_addr_gen;

    localparam int AW = 12;
    localparam int LW = 4;
    localparam int OD = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] n_log2 = '0;
    logic          bit_rev_en = 1'b0;
    logic          continuous = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_sel;
    logic [AW-1:0] addr_out;
    logic          valid_out;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    fft_addr_gen #(
        .ADDR_WIDTH (AW),
        .LOG_WIDTH  (LW),
        .OUT_DELAY  (OD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_log2     (n_log2),
        .bit_rev_en (bit_rev_en),
        .continuous (continuous),
        .stall      (stall),
        .addr       (addr),
        .addr_sel   (addr_sel),
        .addr_out   (addr_out),
        .valid_out  (valid_out),
        .busy       (busy),
        .done       (done)
    );

    int tests  = 0;
    int fails  = 0;
    int cyc_no = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          v;
        logic [AW-1:0] a;
    } ent_t;

    int   m_state = 0;   // 0 idle, 1 run, 2 drain
    int   m_count = 0;
    int   m_n     = 1;
    bit   m_br    = 1'b0;
    ent_t m_pipe[$];

    function automatic int eff_n(int n);
        if (n == 0) return 1;
        if (n > AW) return AW;
        return n;
    endfunction

    // Arithmetic bit reversal: peel LSBs off v and append them to r.
    function automatic int rev(int v, int n);
        int r = 0;
        for (int i = 0; i < n; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic int m_sel();
        return m_br ? rev(m_count, m_n) : m_count;
    endfunction

    function automatic bit m_done();
        if (m_state != 2 || stall) return 1'b0;
        if (!m_pipe[0].v) return 1'b0;
        for (int i = 1; i < OD; i++) begin
            if (m_pipe[i].v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_push(bit v, int a);
        ent_t e;
        e.v = v;
        e.a = AW'(a);
        void'(m_pipe.pop_front());
        m_pipe.push_back(e);
    endtask

    task automatic model_step();
        bit d;
        int s;
        if (!rst_n) begin
            m_state = 0; m_count = 0; m_n = 1; m_br = 1'b0;
            m_pipe.delete();
            for (int i = 0; i < OD; i++) m_pipe.push_back('0);
            return;
        end
        d = m_done();
        s = m_sel();
        case (m_state)
            0: begin
                if (!stall) m_push(1'b0, s);
                if (start) begin
                    m_n = eff_n(int'(n_log2)); m_br = bit_rev_en;
                    m_state = 1; m_count = 0;
                end
            end
            1: if (!stall) begin
                m_push(1'b1, s);
                if (m_count == (1 << m_n) - 1) begin
                    m_count = 0;
                    if (!continuous) m_state = 2;
                end else begin
                    m_count++;
                end
            end
            default: if (!stall) begin
                m_push(1'b0, s);
                if (d) m_state = 0;
            end
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_addr",      32'(addr),      32'(m_count));
        check("model_addr_sel",  32'(addr_sel),  32'(m_sel()));
        check("model_addr_out",  32'(addr_out),  32'(m_pipe[0].a));
        check("model_valid_out", 32'(valid_out), 32'(m_pipe[0].v));
        check("model_busy",      32'(busy),      32'(m_state != 0));
        check("model_done",      32'(done),      32'(m_done()));
    endtask

    task automatic apply(bit s, int n, bit br, bit cn, bit st, bit rn);
        start = s; n_log2 = LW'(n); bit_rev_en = br;
        continuous = cn; stall = st; rst_n = rn;
        #4;
        if (chk_en) compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc_no++;
        #1;
    endtask

    task automatic cyc(bit s, int n, bit br, bit cn, bit st, bit rn);
        apply(s, n, br, cn, st, rn);
        tick();
    endtask

    task automatic wait_done(int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            apply(0, 0, 0, 0, 0, 1);
            if (done === 1'b1) begin
                at = cyc_no;
                tick();
                return;
            end
            tick();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit s; int n; bit br; bit cn; bit st; bit rn;
        int e_addr; int e_sel; int e_out; bit e_vo; bit e_busy; bit e_done;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit s, int n, bit br, bit cn, bit st, bit rn,
                                int ea, int es, int eo, bit ev, bit eb, bit ed);
        vec_t v;
        v.s = s; v.n = n; v.br = br; v.cn = cn; v.st = st; v.rn = rn;
        v.e_addr = ea; v.e_sel = es; v.e_out = eo;
        v.e_vo = ev; v.e_busy = eb; v.e_done = ed;
        tbl.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, dones, done_at;
        int rs, rnn, rbr, rcn, rst_v, rrn;

        // reset state
        add(0,0,0,0,0,1, 0,0,0,0,0,0);
        // natural order, n=3
        add(1,3,0,0,0,1, 0,0,0,0,0,0);
        add(0,3,0,0,0,1, 0,0,0,0,1,0);
        add(0,3,0,0,0,1, 1,1,0,0,1,0);
        add(0,3,0,0,0,1, 2,2,0,0,1,0);
        add(0,3,0,0,0,1, 3,3,0,1,1,0);
        add(0,3,0,0,0,1, 4,4,1,1,1,0);
        add(0,3,0,0,0,1, 5,5,2,1,1,0);
        add(0,3,0,0,0,1, 6,6,3,1,1,0);
        add(0,3,0,0,0,1, 7,7,4,1,1,0);
        add(0,3,0,0,0,1, 0,0,5,1,1,0);
        add(0,3,0,0,0,1, 0,0,6,1,1,0);
        add(0,3,0,0,0,1, 0,0,7,1,1,1);
        add(0,3,0,0,0,1, 0,0,0,0,0,0);
        // bit-reversed, n=3
        add(1,3,1,0,0,1, 0,0,0,0,0,0);
        add(0,3,1,0,0,1, 0,0,0,0,1,0);
        add(0,3,1,0,0,1, 1,4,0,0,1,0);
        add(0,3,1,0,0,1, 2,2,0,0,1,0);
        add(0,3,1,0,0,1, 3,6,0,1,1,0);
        add(0,3,1,0,0,1, 4,1,4,1,1,0);
        add(0,3,1,0,0,1, 5,5,2,1,1,0);
        add(0,3,1,0,0,1, 6,3,6,1,1,0);
        add(0,3,1,0,0,1, 7,7,1,1,1,0);
        add(0,3,1,0,0,1, 0,0,5,1,1,0);
        add(0,3,1,0,0,1, 0,0,3,1,1,0);
        add(0,3,1,0,0,1, 0,0,7,1,1,1);
        add(0,3,1,0,0,1, 0,0,0,0,0,0);

        cyc(0,0,0,0,0,0);
        cyc(0,0,0,0,0,0);
        chk_en = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].s, tbl[i].n, tbl[i].br, tbl[i].cn, tbl[i].st, tbl[i].rn);
            check($sformatf("row%0d_addr", i),      32'(addr),      32'(tbl[i].e_addr));
            check($sformatf("row%0d_addr_sel", i),  32'(addr_sel),  32'(tbl[i].e_sel));
            check($sformatf("row%0d_addr_out", i),  32'(addr_out),  32'(tbl[i].e_out));
            check($sformatf("row%0d_valid_out", i), 32'(valid_out), 32'(tbl[i].e_vo));
            check($sformatf("row%0d_busy", i),      32'(busy),      32'(tbl[i].e_busy));
            check($sformatf("row%0d_done", i),      32'(done),      32'(tbl[i].e_done));
            tick();
        end

        // continuous n=2: three back-to-back frames, one done at the end
        cyc_no = 0; dones = 0; done_at = -1;
        for (int k = 0; k < 30; k++) begin
            apply(k == 0, 2, 0, k <= 10, 0, 1);
            if (k >= 1 && k <= 12) check("cont_addr", 32'(addr), 32'((k - 1) % 4));
            if (done === 1'b1) begin dones++; done_at = k; end
            tick();
        end
        check("cont_done_count", 32'(dones), 32'(1));
        check("cont_done_cycle", 32'(done_at), 32'(15));

        // stall for 5 cycles at count 6, n=4
        cyc_no = 0;
        cyc(1, 4, 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) cyc(0, 4, 0, 0, 0, 1);
        for (int k = 7; k <= 11; k++) begin
            apply(0, 4, 0, 0, 1, 1);
            check("stall_addr",      32'(addr),      32'(6));
            check("stall_addr_out",  32'(addr_out),  32'(3));
            check("stall_valid_out", 32'(valid_out), 32'(1));
            check("stall_done",      32'(done),      32'(0));
            tick();
        end
        apply(0, 4, 0, 0, 0, 1);
        check("stall_hold_addr", 32'(addr), 32'(6));
        tick();
        apply(0, 4, 0, 0, 0, 1);
        check("stall_resume_addr", 32'(addr), 32'(7));
        tick();
        wait_done(40, at);
        check("stall_done_cycle", 32'(at), 32'(24));

        // reset mid-frame at count 5
        cyc_no = 0;
        cyc(1, 4, 0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) cyc(0, 4, 0, 0, 0, 1);
        apply(0, 4, 0, 0, 0, 0);
        check("rst_pre_addr", 32'(addr), 32'(5));
        tick();
        apply(0, 4, 0, 0, 0, 1);
        check("rst_addr",      32'(addr),      32'(0));
        check("rst_addr_sel",  32'(addr_sel),  32'(0));
        check("rst_addr_out",  32'(addr_out),  32'(0));
        check("rst_valid_out", 32'(valid_out), 32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_done",      32'(done),      32'(0));
        tick();
        // start while busy is ignored
        cyc_no = 0;
        cyc(1, 4, 0, 0, 0, 1);
        cyc(0, 4, 0, 0, 0, 1);
        cyc(0, 4, 0, 0, 0, 1);
        apply(1, 4, 0, 0, 0, 1);
        check("busy_start_addr", 32'(addr), 32'(2));
        tick();
        apply(0, 4, 0, 0, 0, 1);
        check("busy_start_next", 32'(addr), 32'(3));
        tick();
        wait_done(40, at);
        check("busy_start_done_cycle", 32'(at), 32'(19));

        // full-width reverse, n=12
        cyc_no = 0;
        cyc(1, 12, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        check("n12_sel_1", 32'(addr_sel), 32'(2048));
        tick();
        for (int k = 3; k <= 4095; k++) cyc(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        check("n12_addr_last", 32'(addr), 32'(4095));
        check("n12_sel_last",  32'(addr_sel), 32'(4095));
        tick();
        wait_done(10, at);
        check("n12_done_cycle", 32'(at), 32'(4099));

        // n_log2=0 behaves as 1
        cyc_no = 0;
        cyc(1, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        check("n0_addr0", 32'(addr), 32'(0));
        tick();
        apply(0, 0, 0, 0, 0, 1);
        check("n0_addr1", 32'(addr), 32'(1));
        tick();
        wait_done(10, at);
        check("n0_done_cycle", 32'(at), 32'(5));

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rs    = ($urandom_range(0, 7) == 0);
            rnn   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(7, 15))
                                                 : int'($urandom_range(0, 5));
            rbr   = int'($urandom_range(0, 1));
            rcn   = ($urandom_range(0, 3) == 0);
            rst_v = ($urandom_range(0, 4) == 0);
            rrn   = ($urandom_range(0, 299) != 0);
            cyc(rs[0], rnn, rbr[0], rcn[0], rst_v[0], rrn[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fft_addr_gen
`default_nettype wire
